// File: rtl/rom_using_case_pkg.sv
// Shared constants for the case-decoded instruction ROM.
//   ROM_DEPTH : number of ROM words (64)
//   DATA_W    : read data width (32)
//   ADDR_W    : word-index address width (32)
//   OOR_DATA  : word returned for addresses at or beyond ROM_DEPTH
//   NOP       : all-zero word used for reset, chip-disable and unused slots
package rom_using_case_pkg;

  localparam int unsigned ROM_DEPTH = 64;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;

  localparam logic [DATA_W-1:0] OOR_DATA = 32'h0000_0000;
  localparam logic [DATA_W-1:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/rom_using_case.sv
// 64-word constant ROM decoded with a case statement on the full address,
// with a registered read port (one-cycle latency).
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears data
//   address : word index (not a byte address)
//   read_en : read request, qualified by ce
//   ce      : chip enable; when low, data is cleared on the next edge
//   data    : registered read data
module rom_using_case
  import rom_using_case_pkg::ROM_DEPTH;
  import rom_using_case_pkg::DATA_W;
  import rom_using_case_pkg::ADDR_W;
  import rom_using_case_pkg::NOP;
#(
  parameter int unsigned        DEPTH    = ROM_DEPTH,
  parameter logic [DATA_W-1:0]  OOR_DATA = rom_using_case_pkg::OOR_DATA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read_en,
  input  logic              ce,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= NOP;
    end else if (!ce) begin
      data <= NOP;
    end else if (read_en) begin
      // Decode uses all 32 address bits so high addresses never alias
      // onto the populated low words.
      case (address)
        32'd0:   data <= 32'h2008_0005;
        32'd1:   data <= 32'h2009_000A;
        32'd2:   data <= 32'h0109_5020;
        32'd3:   data <= 32'h0128_5822;
        32'd4:   data <= 32'h0109_6024;
        32'd5:   data <= 32'h0109_6825;
        32'd6:   data <= 32'h0109_702A;
        32'd7:   data <= 32'hAC0A_0000;
        32'd8:   data <= 32'h8C0F_0000;
        32'd9:   data <= 32'h114F_0001;
        32'd10:  data <= 32'h0000_0000;
        32'd11:  data <= 32'h0800_0000;
        // Unpopulated in-range words read as NOP; only true out-of-range
        // addresses return OOR_DATA, so an override of OOR_DATA does not
        // leak into words 12..63.
        default: data <= (address < DEPTH) ? NOP : OOR_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_using_case.sv
module tb_rom_using_case;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        read_en;
  logic        ce;
  logic [31:0] data;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [31:0] rom_img [64];
  logic [31:0] exp_data;

  rom_using_case #(
    .DEPTH    (64),
    .OOR_DATA (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .read_en (read_en),
    .ce      (ce),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (a >= 32'd64) return 32'h0000_0000;
    return rom_img[a[5:0]];
  endfunction

  // Advance one rising edge, update the reference from the inputs that were
  // presented at that edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (!ce)          exp_data = 32'h0000_0000;
    else if (read_en) exp_data = ref_word(address);
    check(tag, data, exp_data);
  endtask

  task automatic drive(input logic c, input logic r, input logic [31:0] a);
    ce = c;
    read_en = r;
    address = a;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) rom_img[i] = 32'h0000_0000;
    rom_img[0]  = 32'h2008_0005;
    rom_img[1]  = 32'h2009_000A;
    rom_img[2]  = 32'h0109_5020;
    rom_img[3]  = 32'h0128_5822;
    rom_img[4]  = 32'h0109_6024;
    rom_img[5]  = 32'h0109_6825;
    rom_img[6]  = 32'h0109_702A;
    rom_img[7]  = 32'hAC0A_0000;
    rom_img[8]  = 32'h8C0F_0000;
    rom_img[9]  = 32'h114F_0001;
    rom_img[11] = 32'h0800_0000;

    // Reset with a read request pending: data clears without any clock edge.
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'd2);
    #1 rst_n = 1'b0;
    #1 check("reset_async", data, 32'h0000_0000);
    exp_data = 32'h0000_0000;
    // Reads are ignored while reset is held across edges.
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_hold", data, 32'h0000_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First read on the first edge after reset release.
    drive(1'b1, 1'b1, 32'd2);
    step("basic_addr2");
    check("basic_addr2_const", data, 32'h0109_5020);
    drive(1'b1, 1'b1, 32'd234);
    step("basic_addr234");

    // Back-to-back sweep across and past the populated range.
    for (int unsigned a = 0; a <= 70; a++) begin
      drive(1'b1, 1'b1, a);
      step($sformatf("sweep_%0d", a));
    end

    // Gating: read, hold with read_en low, clear with ce low.
    drive(1'b1, 1'b1, 32'd0);
    step("gate_read0");
    check("gate_read0_const", data, 32'h2008_0005);
    drive(1'b1, 1'b0, 32'd1);
    step("gate_hold");
    check("gate_hold_const", data, 32'h2008_0005);
    drive(1'b0, 1'b1, 32'd1);
    step("gate_ce0");
    check("gate_ce0_const", data, 32'h0000_0000);

    // Large addresses must not alias onto words 1 or 63.
    drive(1'b1, 1'b1, 32'd1);
    step("alias_pre");
    drive(1'b1, 1'b1, 32'h0000_0041);
    step("alias_41");
    drive(1'b1, 1'b1, 32'd3);
    step("alias_pre2");
    drive(1'b1, 1'b1, 32'hFFFF_FFFF);
    step("alias_ffff");
    drive(1'b1, 1'b1, 32'h0000_0043);
    step("alias_43");

    // Async reset mid-stream between edges.
    drive(1'b1, 1'b1, 32'd2);
    step("mid_read");
    drive(1'b1, 1'b0, 32'd5);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_drop", data, 32'h0000_0000);
    exp_data = 32'h0000_0000;
    #1 rst_n = 1'b1;
    step("mid_reset_stay0");
    drive(1'b1, 1'b1, 32'd2);
    step("mid_reset_reread");

    // Randomized traffic, with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 11);
        1:       a = $urandom_range(0, 63);
        2:       a = $urandom_range(60, 130);
        default: a = $urandom;
      endcase
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), a);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_reset", data, 32'h0000_0000);
        exp_data = 32'h0000_0000;
        #1 rst_n = 1'b1;
      end
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
